// File: rtl/hex_scan_display_if.sv
// Display driver bus: load strobe, value/dp inputs, enable, and the
// multiplexed anode/segment/dp pins plus the pending flag.
interface hex_scan_display_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   value_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  pending;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dp;

  modport master (
    output en, load, value_in, dp_in,
    input  pending, an, seg, dp
  );

  modport slave (
    input  en, load, value_in, dp_in,
    output pending, an, seg, dp
  );
endinterface

// File: rtl/hex_scan_display.sv
// Time-multiplexed common-anode hex display driver with frame-synchronous load.
// Optional macro HEX_SCAN_ZERO_BLANK_EN blanks leading-zero digits (never digit 0).
module hex_scan_display #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input logic clk,
  input logic rst_n,
  hex_scan_display_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);

  logic [PRE_W-1:0]    prescale_q, prescale_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] activeVal_q, activeVal_d;
  logic [DIGITS-1:0]   activeDp_q, activeDp_d;
  logic [4*DIGITS-1:0] shadowVal_q, shadowVal_d;
  logic [DIGITS-1:0]   shadowDp_q, shadowDp_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic                tick;
  logic                lastDigit;
  logic                frameEnd;
  logic [3:0]          curNib;
  logic                curDp;
  logic [6:0]          segDec;

  function automatic logic [6:0] decodeHex(input logic [3:0] nib);
    case (nib)
      4'h0: decodeHex = 7'b0000001;
      4'h1: decodeHex = 7'b1001111;
      4'h2: decodeHex = 7'b0010010;
      4'h3: decodeHex = 7'b0000110;
      4'h4: decodeHex = 7'b1001100;
      4'h5: decodeHex = 7'b0100100;
      4'h6: decodeHex = 7'b0100000;
      4'h7: decodeHex = 7'b0001111;
      4'h8: decodeHex = 7'b0000000;
      4'h9: decodeHex = 7'b0000100;
      4'hA: decodeHex = 7'b0001000;
      4'hB: decodeHex = 7'b1100000;
      4'hC: decodeHex = 7'b0110001;
      4'hD: decodeHex = 7'b1000010;
      4'hE: decodeHex = 7'b0110000;
      default: decodeHex = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    tick       = (prescale_q == PRE_W'(REFRESH_DIV - 1));
    lastDigit  = (idx_q == IDX_W'(DIGITS - 1));
    frameEnd   = tick && lastDigit;
    prescale_d = tick ? '0 : prescale_q + PRE_W'(1);
    idx_d      = idx_q;
    if (tick) begin
      idx_d = lastDigit ? '0 : idx_q + IDX_W'(1);
    end
  end

  // A load coinciding with the frame boundary bypasses the shadow entirely.
  always_comb begin
    activeVal_d = activeVal_q;
    activeDp_d  = activeDp_q;
    shadowVal_d = shadowVal_q;
    shadowDp_d  = shadowDp_q;
    pending_d   = pending_q;
    if (frameEnd) begin
      if (bus.load) begin
        activeVal_d = bus.value_in;
        activeDp_d  = bus.dp_in;
      end else if (pending_q) begin
        activeVal_d = shadowVal_q;
        activeDp_d  = shadowDp_q;
      end
      pending_d = 1'b0;
    end else if (bus.load) begin
      shadowVal_d = bus.value_in;
      shadowDp_d  = bus.dp_in;
      pending_d   = 1'b1;
    end
  end

  always_comb begin
    curNib = 4'h0;
    curDp  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        curNib = activeVal_q[4*k +: 4];
        curDp  = activeDp_q[k];
      end
    end
    segDec = decodeHex(curNib);
  end

`ifdef HEX_SCAN_ZERO_BLANK_EN
  logic higherZero;
  logic blankCur;

  // Walk from the most significant digit down; a digit is leading-zero while
  // it and every digit above it are zero.
  always_comb begin
    higherZero = 1'b1;
    blankCur   = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      higherZero = higherZero && (activeVal_q[4*k +: 4] == 4'h0);
      if ((k != 0) && higherZero && (idx_q == IDX_W'(k))) begin
        blankCur = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    an_d  = '1;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (bus.en) begin
      an_d  = ~(DIGITS'(1) << idx_q);
`ifdef HEX_SCAN_ZERO_BLANK_EN
      seg_d = blankCur ? 7'b1111111 : segDec;
`else
      seg_d = segDec;
`endif
      dp_d  = ~curDp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescale_q  <= '0;
      idx_q       <= '0;
      activeVal_q <= '0;
      activeDp_q  <= '0;
      shadowVal_q <= '0;
      shadowDp_q  <= '0;
      pending_q   <= 1'b0;
      an_q        <= '1;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
    end else begin
      prescale_q  <= prescale_d;
      idx_q       <= idx_d;
      activeVal_q <= activeVal_d;
      activeDp_q  <= activeDp_d;
      shadowVal_q <= shadowVal_d;
      shadowDp_q  <= shadowDp_d;
      pending_q   <= pending_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.pending = pending_q;
  assign bus.an      = an_q;
  assign bus.seg     = seg_q;
  assign bus.dp      = dp_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display: directed scenarios then random traffic,
// checked against a cycle-count based reference model.
module tb_hex_scan_display;

  localparam int D  = 4;
  localparam int R  = 4;
  localparam int RD = R * D;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pending;
  } expT;

  logic clk;
  logic rst_n;
  hex_scan_display_if #(.DIGITS(D)) bus ();

  hex_scan_display #(.DIGITS(D), .REFRESH_DIV(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  expT        expQ[$];
  int         total = 0;
  int         bad   = 0;
  logic [6:0] segTab [16];

  // Reference model state: cycles since reset release plus displayed/queued values.
  int          n = 0;
  logic [15:0] actV = '0;
  logic [3:0]  actD = '0;
  logic [15:0] pendV = '0;
  logic [3:0]  pendD = '0;
  bit          havePend = 0;
  logic        enState = 1'b1;

  task automatic applyStimulus(input logic rstN, input logic en, input logic ld,
                               input logic [15:0] v, input logic [3:0] d);
    expT e;
    int  digit;
    logic [3:0] nib;
    bit blank;
    @(negedge clk);
    rst_n        = rstN;
    bus.en       = en;
    bus.load     = ld;
    bus.value_in = v;
    bus.dp_in    = d;
    if (!rstN) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.pending = 1'b0;
      n = 0; actV = '0; actD = '0; pendV = '0; pendD = '0; havePend = 0;
    end else begin
      digit = (n / R) % D;
      nib   = 4'((actV >> (4 * digit)) & 16'hF);
`ifdef HEX_SCAN_ZERO_BLANK_EN
      blank = (digit != 0) && ((actV >> (4 * digit)) == 16'h0);
`else
      blank = 0;
`endif
      e.an  = en ? ~(4'b0001 << digit) : 4'hF;
      e.seg = (!en || blank) ? 7'h7F : segTab[nib];
      e.dp  = en ? ~actD[digit] : 1'b1;
      if ((n % RD) == RD - 1) begin
        if (ld) begin
          actV = v; actD = d;
        end else if (havePend) begin
          actV = pendV; actD = pendD;
        end
        havePend = 0;
      end else if (ld) begin
        pendV = v; pendD = d; havePend = 1;
      end
      e.pending = havePend;
      n++;
    end
    expQ.push_back(e);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b1, enState, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic loadAtFrameEnd(input logic [15:0] v, input logic [3:0] d);
    while ((n % RD) != RD - 1) applyStimulus(1'b1, enState, 1'b0, 16'h0, 4'h0);
    applyStimulus(1'b1, enState, 1'b1, v, d);
  endtask

  task automatic checkOutput(input expT e);
    total++;
    if (bus.an !== e.an) begin
      bad++;
      $display("[TB] FAIL an: got %b expected %b at %0t", bus.an, e.an, $time);
    end
    total++;
    if (bus.seg !== e.seg) begin
      bad++;
      $display("[TB] FAIL seg: got %b expected %b at %0t", bus.seg, e.seg, $time);
    end
    total++;
    if (bus.dp !== e.dp) begin
      bad++;
      $display("[TB] FAIL dp: got %b expected %b at %0t", bus.dp, e.dp, $time);
    end
    total++;
    if (bus.pending !== e.pending) begin
      bad++;
      $display("[TB] FAIL pending: got %b expected %b at %0t", bus.pending, e.pending, $time);
    end
  endtask

  // Monitor: one registered output set per clock, compared after the edge settles.
  always @(posedge clk) begin
    expT e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    segTab[0]  = 7'b0000001; segTab[1]  = 7'b1001111; segTab[2]  = 7'b0010010; segTab[3]  = 7'b0000110;
    segTab[4]  = 7'b1001100; segTab[5]  = 7'b0100100; segTab[6]  = 7'b0100000; segTab[7]  = 7'b0001111;
    segTab[8]  = 7'b0000000; segTab[9]  = 7'b0000100; segTab[10] = 7'b0001000; segTab[11] = 7'b1100000;
    segTab[12] = 7'b0110001; segTab[13] = 7'b1000010; segTab[14] = 7'b0110000; segTab[15] = 7'b0111000;
    rst_n = 1'b0; bus.en = 1'b1; bus.load = 1'b0; bus.value_in = '0; bus.dp_in = '0;

    $display("[TB] reset and basic scan");
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    idle(36);

    $display("[TB] mid-frame load");
    while ((n / R) % D != 1) idle(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hA5F1, 4'b0100);
    idle(40);

    $display("[TB] double load and bypass");
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h1111, 4'h0);
    idle(2);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h2222, 4'h0);
    idle(36);
    loadAtFrameEnd(16'h3333, 4'b1001);
    idle(36);

    $display("[TB] enable gating");
    idle(5);
    enState = 1'b0; idle(10);
    enState = 1'b1; idle(20);

    $display("[TB] reset while pending");
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hBEEF, 4'hF);
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hDEAD, 4'hF);
    idle(40);

    $display("[TB] leading zero patterns");
    loadAtFrameEnd(16'h00F0, 4'h0);
    idle(20);
    loadAtFrameEnd(16'h0000, 4'h1);
    idle(20);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      logic rs;
      logic ld;
      rs = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 39) == 0) enState = ~enState;
      ld = ($urandom_range(0, 7) == 0);
      applyStimulus(rs, enState, ld, 16'($urandom), 4'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: %0d entries left, required 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
